// File: rtl/io_periph_pkg.sv
// Shared constants and types for the CPU-visible IO mailbox peripheral.
package io_periph_pkg;

  // Register offsets relative to the peripheral base address.
  localparam logic [7:0] REG_DATA   = 8'h00;
  localparam logic [7:0] REG_STATUS = 8'h01;

  // STATUS register bit positions.
  localparam int ST_RX_NOT_EMPTY = 0;
  localparam int ST_TX_NOT_FULL  = 1;
  localparam int ST_RX_OVERFLOW  = 2;
  localparam int ST_TX_OVERFLOW  = 3;
  localparam int ST_RX_UNDERFLOW = 4;
  localparam int ST_RX_COUNT_LSB = 5;

  // CPU access tracking: each strobe acts once, on entry (write) or exit (read).
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_HELD = 2'd1,
    RD_HELD = 2'd2
  } access_state_e;

endpackage

// File: rtl/io_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers and a head output that reads 0 when empty.
module io_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push
  // alongside it; an empty FIFO never bypasses the pushed word to the head.
  always_comb begin
    do_pop   = pop_i & ~empty_o;
    do_push  = push_i & (~full_o | do_pop);
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/io_mailbox.sv
// CPU IO-mapped mailbox: DATA writes feed the TX FIFO, DATA reads drain the RX FIFO.
module io_mailbox
  import io_periph_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'h10,
  parameter int         DEPTH     = 8
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_ioNCE,
  input  logic [7:0] i_ioAddress,
  input  logic       i_ioNOE,
  input  logic       i_ioNWE,
  input  logic [7:0] i_bus,
  output logic [7:0] o_bus,
  output logic       o_busNOE,
  output logic [7:0] o_txData,
  output logic       o_txValid,
  input  logic       i_txReady,
  input  logic [7:0] i_rxData,
  input  logic       i_rxValid,
  output logic       o_rxReady
);

  localparam int         CW          = $clog2(DEPTH) + 1;
  localparam logic [7:0] DATA_ADDR   = BASE_ADDR + REG_DATA;
  localparam logic [7:0] STATUS_ADDR = BASE_ADDR + REG_STATUS;

  access_state_e state_q, state_d;
  logic          rd_data_q, rd_data_d;
  logic          rx_over_q, rx_over_d;
  logic          tx_over_q, tx_over_d;
  logic          rx_under_q, rx_under_d;

  logic          is_data, is_status, sel, rd, wr, bus_rd;
  logic          tx_push, tx_pop, tx_full, tx_empty;
  logic          rx_pop_req, rx_pop, rx_full, rx_empty;
  logic [2:0]    sts_clr;
  logic [7:0]    rx_head, status;
  logic [2:0]    rx_cnt_sat;
  logic [CW-1:0] rx_count, tx_count;

  assign is_data   = (i_ioAddress == DATA_ADDR);
  assign is_status = (i_ioAddress == STATUS_ADDR);
  assign sel       = ~i_ioNCE & (is_data | is_status);
  assign rd        = sel & ~i_ioNOE;
  assign wr        = sel & ~i_ioNWE & i_ioNOE;

  // The bus is released while reset is asserted, whatever the strobes say.
  assign bus_rd   = rd & ~i_reset;
  assign o_busNOE = ~bus_rd;
  assign o_bus    = ~bus_rd ? 8'h00 : (is_data ? rx_head : status);

  assign o_txValid = ~tx_empty;
  assign o_rxReady = ~rx_full;
  assign tx_pop    = ~tx_empty & i_txReady;
  assign rx_pop    = rx_pop_req & ~rx_empty;

  // STATUS assembly with the RX occupancy saturated to three bits.
  always_comb begin
    rx_cnt_sat = (int'(rx_count) > 7) ? 3'd7 : 3'(rx_count);
    status                  = '0;
    status[ST_RX_NOT_EMPTY] = ~rx_empty;
    status[ST_TX_NOT_FULL]  = ~tx_full;
    status[ST_RX_OVERFLOW]  = rx_over_q;
    status[ST_TX_OVERFLOW]  = tx_over_q;
    status[ST_RX_UNDERFLOW] = rx_under_q;
    status[ST_RX_COUNT_LSB +: 3] = rx_cnt_sat;
  end

  // Access FSM: writes commit on entry, reads pop on exit so o_bus is stable.
  always_comb begin
    state_d    = state_q;
    rd_data_d  = rd_data_q;
    tx_push    = 1'b0;
    sts_clr    = 3'b000;
    rx_pop_req = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr) begin
          state_d = WR_HELD;
          if (is_data) begin
            tx_push = 1'b1;
          end else begin
            sts_clr = i_bus[ST_TX_OVERFLOW+1:ST_RX_OVERFLOW];
          end
        end else if (rd) begin
          state_d   = RD_HELD;
          rd_data_d = is_data;
        end
      end
      WR_HELD: begin
        if (!wr) state_d = IDLE;
      end
      RD_HELD: begin
        if (!rd) begin
          state_d    = IDLE;
          rx_pop_req = rd_data_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sticky error flags: a same-cycle set wins over a CPU clear.
  always_comb begin
    rx_over_d  = (i_rxValid & rx_full & ~rx_pop) |
                 (rx_over_q & ~sts_clr[0]);
    tx_over_d  = (tx_push & tx_full & ~tx_pop) |
                 (tx_over_q & ~sts_clr[1]);
    rx_under_d = (rx_pop_req & rx_empty) |
                 (rx_under_q & ~sts_clr[2]);
  end

  // State and sticky-flag registers; reset aborts any access in progress.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= IDLE;
      rd_data_q  <= 1'b0;
      rx_over_q  <= 1'b0;
      tx_over_q  <= 1'b0;
      rx_under_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_data_q  <= rd_data_d;
      rx_over_q  <= rx_over_d;
      tx_over_q  <= tx_over_d;
      rx_under_q <= rx_under_d;
    end
  end

  io_sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
    .clk_i   (i_clk),
    .rst_i   (i_reset),
    .push_i  (tx_push),
    .pop_i   (tx_pop),
    .din_i   (i_bus),
    .head_o  (o_txData),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count)
  );

  io_sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
    .clk_i   (i_clk),
    .rst_i   (i_reset),
    .push_i  (i_rxValid),
    .pop_i   (rx_pop_req),
    .din_i   (i_rxData),
    .head_o  (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_count)
  );

endmodule

// File: tb/tb_io_mailbox.sv
// Directed bench for io_mailbox: decode table plus hand-written access sequences.
module tb_io_mailbox;

  logic       clk = 1'b0;
  logic       rst;
  logic       nce, noe, nwe;
  logic [7:0] addr, bus_in;
  logic [7:0] bus_out;
  logic       busnoe;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  int errors = 0;
  int checks = 0;

  io_mailbox dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_ioNCE     (nce),
    .i_ioAddress (addr),
    .i_ioNOE     (noe),
    .i_ioNWE     (nwe),
    .i_bus       (bus_in),
    .o_bus       (bus_out),
    .o_busNOE    (busnoe),
    .o_txData    (tx_data),
    .o_txValid   (tx_valid),
    .i_txReady   (tx_ready),
    .i_rxData    (rx_data),
    .i_rxValid   (rx_valid),
    .o_rxReady   (rx_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       nce;
    logic [7:0] addr;
    logic       noe;
    logic       nwe;
    logic [7:0] din;
    logic       exp_noe;
    logic [7:0] exp_bus;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%02h", name, act);
    end
  endtask

  task automatic idle_bus();
    nce    = 1'b1;
    noe    = 1'b1;
    nwe    = 1'b1;
    addr   = 8'h00;
    bus_in = 8'h00;
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [7:0] d, input int len);
    @(negedge clk);
    nce = 1'b0; addr = a; bus_in = d; noe = 1'b1; nwe = 1'b0;
    repeat (len) @(negedge clk);
    idle_bus();
    @(negedge clk);
  endtask

  task automatic cpu_read(input logic [7:0] a, input int len, input logic [7:0] exp,
                          input string name);
    @(negedge clk);
    nce = 1'b0; addr = a; noe = 1'b0; nwe = 1'b1;
    for (int i = 0; i < len; i++) begin
      #1;
      chk({name, " busNOE"}, {7'd0, busnoe}, 8'h00);
      chk({name, " data"}, bus_out, exp);
      @(negedge clk);
    end
    idle_bus();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Decode vectors applied right after reset: STATUS reads 0x02 (TX not full only).
    vecs[0] = '{1'b1, 8'h10, 1'b0, 1'b1, 8'h00, 1'b1, 8'h00};
    vecs[1] = '{1'b0, 8'h11, 1'b0, 1'b1, 8'h00, 1'b0, 8'h02};
    vecs[2] = '{1'b0, 8'h12, 1'b0, 1'b1, 8'h00, 1'b1, 8'h00};
    vecs[3] = '{1'b0, 8'h0F, 1'b0, 1'b1, 8'h00, 1'b1, 8'h00};
    vecs[4] = '{1'b0, 8'h11, 1'b1, 1'b1, 8'h00, 1'b1, 8'h00};
    vecs[5] = '{1'b0, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0, 8'h02};
    vecs[6] = '{1'b0, 8'h11, 1'b1, 1'b0, 8'h1C, 1'b1, 8'h00};

    rst = 1'b1;
    idle_bus();
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;

    // Reset values, including a read attempted while reset is held.
    #2;
    chk("reset txValid", {7'd0, tx_valid}, 8'h00);
    chk("reset rxReady", {7'd0, rx_ready}, 8'h01);
    chk("reset txData", tx_data, 8'h00);
    nce = 1'b0; addr = 8'h11; noe = 1'b0;
    #1;
    chk("reset-read busNOE", {7'd0, busnoe}, 8'h01);
    chk("reset-read bus", bus_out, 8'h00);
    idle_bus();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Address decode and bus-drive table.
    for (int v = 0; v < 7; v++) begin
      @(negedge clk);
      nce = vecs[v].nce; addr = vecs[v].addr; noe = vecs[v].noe;
      nwe = vecs[v].nwe; bus_in = vecs[v].din;
      #1;
      chk($sformatf("vec%0d busNOE", v), {7'd0, busnoe}, {7'd0, vecs[v].exp_noe});
      chk($sformatf("vec%0d bus", v), bus_out, vecs[v].exp_bus);
      @(negedge clk);
      idle_bus();
    end
    @(negedge clk);

    // Two long-strobe DATA writes, then delivery to the local consumer.
    cpu_write(8'h10, 8'h41, 3);
    cpu_write(8'h10, 8'h42, 3);
    chk("tx2 valid", {7'd0, tx_valid}, 8'h01);
    chk("tx2 head", tx_data, 8'h41);
    @(negedge clk);
    tx_ready = 1'b1;
    #1;
    chk("deliver first", tx_data, 8'h41);
    @(negedge clk);
    #1;
    chk("deliver second", tx_data, 8'h42);
    chk("deliver second valid", {7'd0, tx_valid}, 8'h01);
    @(negedge clk);
    #1;
    chk("tx drained valid", {7'd0, tx_valid}, 8'h00);
    tx_ready = 1'b0;

    // Nine writes into an eight-deep TX FIFO: the last one overflows.
    for (int i = 0; i < 9; i++) cpu_write(8'h10, 8'h50 + 8'(i), 1);
    chk("tx full head", tx_data, 8'h50);
    cpu_read(8'h11, 1, 8'h08, "status txOverflow");
    cpu_write(8'h11, 8'h08, 2);
    cpu_read(8'h11, 1, 8'h00, "status txOverflow cleared");

    // One local RX push, then a five-cycle DATA read with a stable bus.
    @(negedge clk);
    rx_valid = 1'b1; rx_data = 8'hA5;
    @(negedge clk);
    rx_valid = 1'b0;
    cpu_read(8'h11, 1, 8'h21, "status rx one");
    cpu_read(8'h10, 5, 8'hA5, "long read");
    cpu_read(8'h11, 1, 8'h00, "status after pop");

    // Read of an empty RX, then an unmapped address.
    cpu_read(8'h10, 2, 8'h00, "empty read");
    cpu_read(8'h11, 1, 8'h10, "status rxUnderflow");
    @(negedge clk);
    nce = 1'b0; addr = 8'h12; noe = 1'b0;
    #1;
    chk("unmapped busNOE", {7'd0, busnoe}, 8'h01);
    chk("unmapped bus", bus_out, 8'h00);
    @(negedge clk);
    idle_bus();
    cpu_write(8'h11, 8'h10, 1);
    cpu_read(8'h11, 1, 8'h00, "status underflow cleared");

    // Fill RX, then push in the same cycle the DATA read ends.
    @(negedge clk);
    rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rx_data = 8'hC0 + 8'(i);
      @(negedge clk);
    end
    rx_valid = 1'b0;
    #1;
    chk("rx full ready", {7'd0, rx_ready}, 8'h00);
    cpu_read(8'h11, 1, 8'hE1, "status rx full");
    @(negedge clk);
    nce = 1'b0; addr = 8'h10; noe = 1'b0; nwe = 1'b1;
    #1;
    chk("full read data", bus_out, 8'hC0);
    @(negedge clk);
    idle_bus();
    rx_valid = 1'b1; rx_data = 8'hD8;
    @(negedge clk);
    rx_valid = 1'b0;
    #1;
    chk("push+pop still full", {7'd0, rx_ready}, 8'h00);
    cpu_read(8'h11, 1, 8'hE1, "status no rxOverflow");
    for (int i = 0; i < 8; i++) begin
      cpu_read(8'h10, 1, (i < 7) ? (8'hC1 + 8'(i)) : 8'hD8, $sformatf("drain%0d", i));
    end
    cpu_read(8'h11, 1, 8'h00, "status rx drained");

    // Drain TX, then reset in the middle of a held DATA write.
    @(negedge clk);
    tx_ready = 1'b1;
    repeat (10) @(negedge clk);
    tx_ready = 1'b0;
    #1;
    chk("tx drain before reset", {7'd0, tx_valid}, 8'h00);
    @(negedge clk);
    nce = 1'b0; addr = 8'h10; bus_in = 8'h77; noe = 1'b1; nwe = 1'b0;
    @(negedge clk);
    #1;
    chk("held write committed", {7'd0, tx_valid}, 8'h01);
    rst = 1'b1;
    #1;
    chk("reset aborts push", {7'd0, tx_valid}, 8'h00);
    @(negedge clk);
    #1;
    chk("reset held no push", {7'd0, tx_valid}, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("post-reset push valid", {7'd0, tx_valid}, 8'h01);
    chk("post-reset push data", tx_data, 8'h77);
    @(negedge clk);
    idle_bus();
    @(negedge clk);
    tx_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("single post-reset push", {7'd0, tx_valid}, 8'h00);
    tx_ready = 1'b0;
    cpu_read(8'h11, 1, 8'h02, "status after reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/io_mailbox.md
IO_MAILBOX -- requirements
Module: io_mailbox

Interface
REQ-001 The parameter list SHALL be: BASE_ADDR, default 8'h10, IO address of the DATA register (STATUS is BASE_ADDR+1).
REQ-002 The parameter list SHALL include: DEPTH, default 8, entries per FIFO (power of two, 2..64).
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset; all IO strobes are synchronous to i_clk.
REQ-004 The ports SHALL be:
 i_clk  in  1  clock
 i_reset  in  1  async active-high reset
 i_ioNCE  in  1  IO chip enable, active low
 i_ioAddress  in  8  IO register address
 i_ioNOE  in  1  read strobe, active low
 i_ioNWE  in  1  write strobe, active low
 i_bus  in  8  write data from CPU
 o_bus  out  8  read data to CPU
 o_busNOE  out  1  0 = block drives o_bus
 o_txData  out  8  TX FIFO head
 o_txValid  out  1  TX FIFO not empty
 i_txReady  in  1  local consumer pops TX head when o_txValid&i_txReady
 i_rxData  in  8  local producer data
 i_rxValid  in  1  local push request
 o_rxReady  out  1  RX FIFO not full

Function
REQ-005 Select SHALL be: sel = !i_ioNCE & (i_ioAddress==BASE_ADDR | i_ioAddress==BASE_ADDR+1); rd = sel & !i_ioNOE; wr = sel & !i_ioNWE & i_ioNOE.
REQ-006 o_busNOE SHALL be combinationally !rd; o_bus = DATA ? RX head (8'h00 if empty) : STATUS; o_bus = 8'h00 when !rd.
REQ-007 STATUS SHALL be {rxCount[2:0], rxUnderflow, txOverflow, rxOverflow, txNotFull, rxNotEmpty} (bit7..0), rxCount saturating at 7.
REQ-008 Access FSM states SHALL be IDLE, WR_HELD and RD_HELD: IDLE->WR_HELD on wr (commit the write in that cycle); IDLE->RD_HELD on rd; WR_HELD->IDLE when !wr; RD_HELD->IDLE when !rd.
REQ-009 Each access SHALL act exactly once regardless of strobe length.
REQ-010 A DATA write SHALL push i_bus into TX; if TX is full and there is no simultaneous TX pop, data is dropped and txOverflow is set.
REQ-011 A STATUS write SHALL clear each sticky bit (bits 2..4) whose i_bus bit is 1; other bits are ignored.
REQ-012 A DATA read SHALL pop RX on the RD_HELD->IDLE transition (end of access), so o_bus stays stable for the whole strobe; read of an empty RX pops nothing and sets rxUnderflow.
REQ-013 A read whose address changes mid-strobe SHALL still pop only if the address was DATA at entry to RD_HELD.
REQ-014 A local RX push (i_rxValid&o_rxReady) SHALL write i_rxData; i_rxValid while full sets rxOverflow, and the data is dropped.
REQ-015 On simultaneous push and pop to a full FIFO, both SHALL succeed (count unchanged); on an empty FIFO, push only (no bypass).
REQ-016 FIFO pointers SHALL be log2(DEPTH)+1 bits, wrapping modulo 2*DEPTH; full = MSBs differ and LSBs equal.
REQ-017 The latency from push to head visibility SHALL be 1 cycle (o_txValid/rxNotEmpty rise the cycle after the push).
REQ-018 Overflow and underflow flags SHALL be sticky until cleared by REQ-011 or reset; set takes priority over a same-cycle clear.

Reset
REQ-019 On i_reset the block SHALL asynchronously set: FSM=IDLE, both FIFOs empty, all sticky bits 0, o_txValid=0, o_rxReady=1, o_txData=0.
REQ-020 While i_reset is high, o_busNOE SHALL be 1 and o_bus SHALL be 0.
REQ-021 Reset mid-access SHALL abort the access (no push, no pop); an access still held after reset release SHALL be treated as new.

Structure
REQ-022 Package io_periph_pkg SHALL hold the register offsets (DATA=0, STATUS=1), the STATUS bit positions and the access-state enum.
REQ-023 A sub-module io_sync_fifo (params WIDTH, DEPTH; push/pop/full/empty/count/head) SHALL be instantiated twice, for TX and RX.

Verification
REQ-024 CPU writes 0x41,0x42 to 0x10 with 3-cycle NWE strobes, i_txReady=0 -> TX count 2, o_txData=0x41; raise i_txReady -> 0x41 then 0x42 delivered, o_txValid falls.
REQ-025 9 writes to 0x10 with DEPTH=8 -> 9th dropped, STATUS bit3=1; write 0x08 to 0x11 -> bit3 clears.
REQ-026 Local pushes 0xA5 then a 5-cycle read of 0x10 -> o_busNOE=0 and o_bus=0xA5 for all 5 cycles, pop after the strobe, STATUS=0x00 afterwards (TX still full reports bit1=0).
REQ-027 Read of 0x10 with RX empty -> o_bus=0x00, bit4 set; a read of 0x12 -> o_busNOE stays 1.
REQ-028 RX full, same cycle as the read end plus i_rxValid -> count stays 8, no overflow.
REQ-029 i_reset asserted during a held write strobe -> no push; after release, the held strobe commits one push.
